// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared Q8.8 constants, FSM encoding and layer geometry defaults
package nn_pkg;

    // Q8.8 fixed point format
    localparam int          FRAC_BITS = 8;
    localparam logic [15:0] Q_MAX     = 16'h7FFF;
    localparam logic [15:0] Q_MIN     = 16'h8000;

    // Layer geometry, shared with the network controller
    localparam int IN_N_DEF  = 4;
    localparam int NEU_N_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/q88_sat_act.sv
// rtl/q88_sat_act.sv - accumulator to Q8.8 shift, saturate and optional ReLU
//
// Ports:
//   i_acc   signed accumulator, ACC_W bits, FRAC_BITS*2 fractional bits
//   i_relu  1 = clamp negative results to zero
//   o_q     DATA_W-bit Q8.8 result
module q88_sat_act
    import nn_pkg::*;
#(
    parameter int ACC_W  = 40,
    parameter int DATA_W = 16
) (
    input  logic signed [ACC_W-1:0]  i_acc,
    input  logic                     i_relu,
    output logic        [DATA_W-1:0] o_q
);

    // Largest / smallest DATA_W signed values, held at accumulator width
    localparam logic signed [ACC_W-1:0] L_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] L_MIN = ~L_MAX;

    logic signed [ACC_W-1:0] w_sh;

    always_comb begin
        w_sh = i_acc >>> FRAC_BITS;
        if (w_sh > L_MAX) begin
            o_q = L_MAX[DATA_W-1:0];
        end else if (w_sh < L_MIN) begin
            o_q = L_MIN[DATA_W-1:0];
        end else begin
            o_q = w_sh[DATA_W-1:0];
        end
        if (i_relu && o_q[DATA_W-1]) begin
            o_q = '0;
        end
    end

endmodule

// File: rtl/layer_mac_engine.sv
// rtl/layer_mac_engine.sv - per-layer multiply-accumulate engine writing one result per neuron
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   start, layer, layer_sel        one-cycle launch, layer index, 1 = ReLU / 0 = linear
//   w_rd, w_addr, w_data           weight RAM read port (1-cycle latency)
//   a_rd, a_addr, a_bank, a_data   activation RAM read port (1-cycle latency)
//   o_we, o_addr, o_bank, o_data   result write port into the opposite bank
//   busy, done                     engine active / one-cycle completion pulse
module layer_mac_engine
    import nn_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int IN_N   = IN_N_DEF,
    parameter int NEU_N  = NEU_N_DEF,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        layer,
    input  logic              layer_sel,
    output logic              w_rd,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              a_rd,
    output logic [ADDR_W-1:0] a_addr,
    output logic              a_bank,
    input  logic [DATA_W-1:0] a_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_bank,
    output logic [DATA_W-1:0] o_data,
    output logic              busy,
    output logic              done
);

    localparam int K_W = (IN_N  > 1) ? $clog2(IN_N)  : 1;
    localparam int N_W = (NEU_N > 1) ? $clog2(NEU_N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(IN_N - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NEU_N - 1);

    state_t                  r_state;
    logic [K_W-1:0]          r_k;
    logic [N_W-1:0]          r_n;
    logic [1:0]              r_layer;
    logic                    r_relu;
    logic                    r_pend;     // RAM data returned this cycle belongs to a fetch
    logic signed [ACC_W-1:0] r_acc;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic [DATA_W-1:0]          w_act;

    function automatic logic [ADDR_W-1:0] f_waddr(input logic [1:0]     lay,
                                                  input logic [N_W-1:0] n,
                                                  input logic [K_W-1:0] k);
        return ADDR_W'(lay) * ADDR_W'(NEU_N * IN_N) + ADDR_W'(n) * ADDR_W'(IN_N) + ADDR_W'(k);
    endfunction

    assign w_prod     = $signed(w_data) * $signed(a_data);
    assign w_acc_next = r_pend ? (r_acc + ACC_W'(w_prod)) : r_acc;

    // Result is taken from w_acc_next in DRAIN so the last product is included
    q88_sat_act #(.ACC_W(ACC_W), .DATA_W(DATA_W)) u_act (
        .i_acc  (w_acc_next),
        .i_relu (r_relu),
        .o_q    (w_act)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_n     <= '0;
            r_layer <= '0;
            r_relu  <= 1'b0;
            r_pend  <= 1'b0;
            r_acc   <= '0;
            w_rd    <= 1'b0;
            w_addr  <= '0;
            a_rd    <= 1'b0;
            a_addr  <= '0;
            a_bank  <= 1'b0;
            o_we    <= 1'b0;
            o_addr  <= '0;
            o_bank  <= 1'b0;
            o_data  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_pend <= w_rd;
            r_acc  <= w_acc_next;
            o_we   <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FETCH;
                        r_layer <= layer;
                        r_relu  <= layer_sel;
                        a_bank  <= layer[0];
                        o_bank  <= ~layer[0];
                        r_n     <= '0;
                        r_k     <= '0;
                        w_rd    <= 1'b1;
                        a_rd    <= 1'b1;
                        w_addr  <= f_waddr(layer, '0, '0);
                        a_addr  <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // Nothing is returning in a neuron's first fetch cycle, so clearing here is safe
                    if (r_k == '0) begin
                        r_acc <= '0;
                    end
                    if (r_k == K_LAST) begin
                        r_state <= ST_DRAIN;
                        w_rd    <= 1'b0;
                        a_rd    <= 1'b0;
                    end else begin
                        r_k    <= r_k + 1'b1;
                        w_addr <= f_waddr(r_layer, r_n, r_k + 1'b1);
                        a_addr <= ADDR_W'(r_k + 1'b1);
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_WRITE;
                    o_we    <= 1'b1;
                    o_addr  <= ADDR_W'(r_n);
                    o_data  <= w_act;
                    r_k     <= '0;
                end
                ST_WRITE: begin
                    if (r_n == N_LAST) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_state <= ST_FETCH;
                        r_n     <= r_n + 1'b1;
                        w_rd    <= 1'b1;
                        a_rd    <= 1'b1;
                        w_addr  <= f_waddr(r_layer, r_n + 1'b1, '0);
                        a_addr  <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
